pe_operand_seq: RTL and testbench
=================================

Name: pe_operand_seq

Overview:
Operand staging and sequencing stage that sits directly upstream of the PE's parameterised operand multiplexer.
- Captures a burst of up to DEPTH operands from a valid/ready input stream into a register bank.
- Presents the whole bank as the mux's parallel data array.
- Drives the mux select through the loaded entries for a configurable number of reuse passes, with a valid/ready output handshake toward the PE datapath.

Parameters:
WIDTH, 8, operand data width
DEPTH, 8, number of register-bank entries (mux input count)
SEL_WIDTH, $clog2(DEPTH), select / pointer width
PASS_WIDTH, 8, width of the pass-count configuration

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin a load/stream job; sampled only in IDLE
cfg_last  input  SEL_WIDTH  index of last used entry (job length = cfg_last+1), latched on accepted start
cfg_passes  input  PASS_WIDTH  number of sweeps; 0 treated as 1; latched on accepted start
in_valid  input  1  input operand valid
in_ready  output  1  block accepts an operand
in_data  input  WIDTH  input operand
buf_data  output  WIDTH x [0:DEPTH-1]  register bank, feeds mux data array
sel  output  SEL_WIDTH  current read index, feeds mux select
out_valid  output  1  sel points at a valid operand
out_ready  input  1  downstream consumed current operand
out_last  output  1  current operand is the final one of the final pass
busy  output  1  state != IDLE
done  output  1  one-cycle pulse after the final output handshake

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; all buf_data entries=0; sel=0; write pointer=0; pass counter=0; in_ready=0; out_valid=0; out_last=0; busy=0; done=0. Reset asserted mid-job aborts the job immediately; partial data is discarded (bank cleared).
- State IDLE:
  - in_ready=0, out_valid=0.
  - start=1 latches cfg_last and passes_eff (=max(cfg_passes,1)), clears the write pointer, and moves to LOAD next cycle.
  - Bank contents are retained in IDLE.
- State LOAD:
  - in_ready=1, out_valid=0.
  - Each in_valid&in_ready cycle writes in_data to buf[wptr]. The write is visible on buf_data the next cycle.
  - If wptr==cfg_last: go to STREAM with sel=0 and pass counter=0. Otherwise wptr++.
  - Entries above cfg_last keep their previous values.
  - in_valid=0 stalls indefinitely, with no timeout.
- State STREAM:
  - in_ready=0, out_valid=1, sel=read index. buf_data is stable for the whole state.
  - First out_valid occurs the cycle after the handshake that wrote the last entry (1-cycle load-to-stream latency).
  - On out_valid&out_ready:
    - If sel!=cfg_last: sel++.
    - Else if pass counter<passes_eff-1: sel=0 and pass counter++ (wrap, no bubble).
    - Else: go to IDLE, sel=0, and pulse done=1 for one cycle (done is registered and asserts in the first IDLE cycle).
  - out_ready=0 holds sel and out_valid unchanged.
  - out_last = (sel==cfg_last) && (pass counter==passes_eff-1) && STREAM. It is combinational from registered state.
- start outside IDLE is ignored. start in the same cycle as done (already IDLE) is accepted.
- Changes to cfg_* after an accepted start have no effect on the running job.
- cfg_last=0 gives a single-entry job: sel stays 0 and each handshake counts one pass.
- Total output handshakes per job = (cfg_last+1)*passes_eff. Minimum job duration = (cfg_last+1) + (cfg_last+1)*passes_eff + 1 cycles from start.
- No arithmetic overflow is possible: the pass counter is PASS_WIDTH bits and passes_eff ≤ 2^PASS_WIDTH-1.

Test Plan:
1. Reset, then start with cfg_last=7, cfg_passes=1; stream in 0x10..0x17 back-to-back with out_ready=1 -> sel 0..7 on 8 consecutive cycles, buf_data[sel]=0x10+sel, out_last only at sel=7, done pulses the next cycle, busy returns to 0.
2. cfg_last=3, cfg_passes=3, out_ready=1 -> sel sequence 0,1,2,3 repeated 3 times (12 handshakes, no bubbles); out_last only on the 12th; buf_data[4..7] unchanged from the previous job.
3. Randomised in_valid gaps and out_ready toggling, cfg_last=5, cfg_passes=2 -> no write on in_valid=0; sel holds while out_ready=0; exactly 12 handshakes in order 0..5,0..5.
4. cfg_passes=0 and cfg_last=0, single input 0xAA -> exactly one output handshake at sel=0 with out_last=1; done follows.
5. Assert start during LOAD and STREAM, and change cfg_last mid-job -> no effect; job completes with the original configuration.
6. rst_n=0 mid-STREAM (sel=2) -> next cycle IDLE, all buf_data=0, sel=0, out_valid=0, done=0; a new job after reset runs correctly.

Source files
------------

// File: rtl/pe_operand_seq.sv
// Operand staging bank and select sequencer feeding the PE operand mux.
// Loads a burst of operands, then sweeps the select over them for N passes.
module pe_operand_seq #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned SEL_WIDTH  = $clog2(DEPTH),
    parameter int unsigned PASS_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [SEL_WIDTH-1:0]  cfg_last,
    input  logic [PASS_WIDTH-1:0] cfg_passes,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic [WIDTH-1:0]      buf_data [0:DEPTH-1],
    output logic [SEL_WIDTH-1:0]  sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t                state;
    logic [SEL_WIDTH-1:0]  wptr;
    logic [SEL_WIDTH-1:0]  last_q;
    logic [PASS_WIDTH-1:0] passes_q;
    logic [PASS_WIDTH-1:0] pass_cnt;
    logic [PASS_WIDTH-1:0] pass_final;

    // passes_q is never zero, so this cannot underflow.
    assign pass_final = passes_q - PASS_WIDTH'(1);

    assign busy     = (state != IDLE);
    assign out_last = (state == STREAM) && (sel == last_q) && (pass_cnt == pass_final);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wptr      <= '0;
            last_q    <= '0;
            passes_q  <= PASS_WIDTH'(1);
            pass_cnt  <= '0;
            sel       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        last_q   <= cfg_last;
                        passes_q <= (cfg_passes == '0) ? PASS_WIDTH'(1) : cfg_passes;
                        wptr     <= '0;
                        in_ready <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        buf_data[wptr] <= in_data;
                        if (wptr == last_q) begin
                            sel       <= '0;
                            pass_cnt  <= '0;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= STREAM;
                        end else begin
                            wptr <= wptr + SEL_WIDTH'(1);
                        end
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (sel != last_q) begin
                            sel <= sel + SEL_WIDTH'(1);
                        end else if (pass_cnt != pass_final) begin
                            sel      <= '0;
                            pass_cnt <= pass_cnt + PASS_WIDTH'(1);
                        end else begin
                            sel       <= '0;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_operand_seq.sv
// Scoreboard bench for pe_operand_seq: stimulus pushes expected handshakes,
// a negedge monitor pops and compares them.
module tb_pe_operand_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] cfg_last = '0;
    logic [7:0] cfg_passes = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [7:0] buf_data [0:7];
    logic [2:0] sel;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    bit rdy_mode = 1'b0;
    int tick = 0;

    typedef struct { int s; int d; int l; } exp_t;
    exp_t sb[$];
    int   mbank [0:7];

    pe_operand_seq #(.WIDTH(8), .DEPTH(8), .SEL_WIDTH(3), .PASS_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_last(cfg_last),
        .cfg_passes(cfg_passes), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .buf_data(buf_data), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_mode ? ((tick % 3) != 2) : 1'b1;
            tick++;
        end
    end

    // Monitor: every output handshake must match the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                chk("in_ready_stream", in_ready, 0);
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_handshake", sel, -1);
                    end else begin
                        e = sb.pop_front();
                        chk("sel", sel, e.s);
                        chk("buf_data_sel", buf_data[sel], e.d);
                        chk("out_last", out_last, e.l);
                    end
                end
            end
        end
    end

    task automatic wait_end(input int total, input bit noise);
        int  hs = 0;
        int  vc = 0;
        bit  got = 1'b0;
        bit  first = 1'b1;
        bit  lastflag;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (first) begin
                chk("load_to_stream_latency", out_valid, 1);
                first = 1'b0;
            end
            if (done) begin
                got = 1'b1;
                break;
            end
            if (out_valid) vc++;
            lastflag = out_valid && out_ready && out_last;
            if (out_valid && out_ready) hs++;
            @(posedge clk);
            #1;
            if (noise) start = !lastflag;
        end
        start = 1'b0;
        chk("done_seen", got, 1);
        chk("busy_at_done", busy, 0);
        chk("handshake_count", hs, total);
        if (!rdy_mode) chk("no_bubbles", vc, total);
        chk("scoreboard_empty", sb.size(), 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic run_job(input int last, input int passes, input int base,
                           input bit gaps, input bit noise, input bit wait_done);
        int   eff;
        exp_t e;
        eff = (passes == 0) ? 1 : passes;
        for (int i = 0; i <= last; i++) mbank[i] = (base + i) & 8'hFF;
        for (int p = 0; p < eff; p++) begin
            for (int s = 0; s <= last; s++) begin
                e.s = s;
                e.d = mbank[s];
                e.l = (p == eff - 1) && (s == last);
                sb.push_back(e);
            end
        end
        start      = 1'b1;
        cfg_last   = last[2:0];
        cfg_passes = passes[7:0];
        @(posedge clk);
        #1;
        start = noise;
        if (noise) begin
            cfg_last   = 3'd6;
            cfg_passes = 8'd9;
        end
        chk("in_ready_load", in_ready, 1);
        chk("busy_load", busy, 1);
        for (int i = 0; i <= last; i++) begin
            if (gaps) begin
                repeat (i % 3) begin
                    in_valid = 1'b0;
                    in_data  = 8'hEE;
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = 8'((base + i) & 8'hFF);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = 8'hEE;
        if (wait_done) wait_end((last + 1) * eff, noise);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) mbank[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_sel", sel, 0);
        chk("rst_done", done, 0);
        for (int i = 0; i < 8; i++) chk("rst_buf", buf_data[i], 0);
        @(posedge clk);
        #1;

        run_job(7, 1, 8'h10, 1'b0, 1'b0, 1'b1);

        run_job(3, 3, 8'h20, 1'b0, 1'b0, 1'b1);
        for (int i = 4; i < 8; i++) chk("bank_upper_kept", buf_data[i], mbank[i]);

        rdy_mode = 1'b1;
        run_job(5, 2, 8'h30, 1'b1, 1'b0, 1'b1);
        rdy_mode = 1'b0;

        run_job(0, 0, 8'hAA, 1'b0, 1'b0, 1'b1);

        run_job(4, 2, 8'h40, 1'b1, 1'b1, 1'b1);

        run_job(7, 1, 8'h50, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_valid && sel == 3'd2) break;
        end
        chk("pre_reset_sel", sel, 2);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        for (int i = 0; i < 8; i++) mbank[i] = 0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_sel", sel, 0);
        chk("abort_done", done, 0);
        for (int i = 0; i < 8; i++) chk("abort_buf", buf_data[i], 0);
        @(posedge clk);
        #1;

        run_job(7, 1, 8'h60, 1'b0, 1'b0, 1'b1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
